// File: rtl/z80_bus_pkg.sv
// Shared Z80 bus definitions: responder states, wait counter width and
// the strobe decoder used to classify the current bus cycle.
package z80_bus_pkg;

  localparam int WAIT_CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_HOLD,
    ST_INTA
  } io_state_e;

  typedef enum logic [1:0] {
    CYC_NONE,
    CYC_IO_RD,
    CYC_IO_WR,
    CYC_INTA
  } bus_cycle_e;

  // Refresh or an idle IORQ never counts; an I/O cycle needs exactly one of RD/WR.
  function automatic bus_cycle_e decode_strobes(
    input logic n_m1,
    input logic n_iorq,
    input logic n_rd,
    input logic n_wr,
    input logic n_rfsh
  );
    bus_cycle_e cyc;
    cyc = CYC_NONE;
    if (!n_rfsh || n_iorq) begin
      cyc = CYC_NONE;
    end else if (!n_m1) begin
      cyc = CYC_INTA;
    end else if (!n_rd && n_wr) begin
      cyc = CYC_IO_RD;
    end else if (n_rd && !n_wr) begin
      cyc = CYC_IO_WR;
    end
    return cyc;
  endfunction

endpackage

// File: rtl/z80_wait_gen.sv
// Loadable saturating wait-state counter plus the registered n_WAIT line.
module z80_wait_gen
  import z80_bus_pkg::*;
#(
  parameter int WAIT_STATES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,          // access accepted: start counting, pull n_WAIT low
  input  logic run,           // access in progress: count down
  input  logic wait_done,     // access finished or aborted: release n_WAIT
  output logic cnt_expiring,  // counter is 0 after this cycle's decrement
  output logic n_wait
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_STATES);

  logic [WAIT_CNT_W-1:0] cnt_reg;
  logic [WAIT_CNT_W-1:0] cnt_dec;
  logic                  n_wait_reg;

  // Saturating decrement value and its zero flag.
  always_comb begin
    cnt_dec      = (cnt_reg == '0) ? '0 : cnt_reg - WAIT_CNT_W'(1);
    cnt_expiring = (cnt_dec == '0);
  end

  // Counter and n_WAIT register; load wins over run, done parks the counter at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg    <= '0;
      n_wait_reg <= 1'b1;
    end else begin
      if (load) begin
        cnt_reg <= WAIT_INIT;
      end else if (wait_done) begin
        cnt_reg <= '0;
      end else if (run) begin
        cnt_reg <= cnt_dec;
      end
      if (load) begin
        n_wait_reg <= 1'b0;
      end else if (wait_done) begin
        n_wait_reg <= 1'b1;
      end
    end
  end

  assign n_wait = n_wait_reg;

endmodule

// File: rtl/z80_io_responder.sv
// Z80 I/O port responder: decodes I/O cycles on a masked port range, runs a
// handshake with a backend while holding the CPU in wait states, and answers
// mode-2 interrupt acknowledge cycles with a fixed vector.
module z80_io_responder
  import z80_bus_pkg::*;
#(
  parameter logic [7:0] IO_BASE     = 8'h40,
  parameter logic [7:0] IO_MASK     = 8'hF0,
  parameter int         WAIT_STATES = 2,
  parameter logic [7:0] VECTOR      = 8'hE0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] A,
  input  logic [7:0]  D_IN,
  output logic [7:0]  D_OUT,
  output logic        D_OE,
  input  logic        n_M1,
  input  logic        n_IORQ,
  input  logic        n_RD,
  input  logic        n_WR,
  input  logic        n_RFSH,
  output logic        n_WAIT,
  output logic        n_INT,
  output logic        BE_REQ,
  output logic        BE_WE,
  output logic [3:0]  BE_ADDR,
  output logic [7:0]  BE_WDATA,
  input  logic [7:0]  BE_RDATA,
  input  logic        BE_ACK,
  input  logic        IRQ,
  output logic        IRQ_ACK
);

  io_state_e  state_reg, state_next;
  bus_cycle_e cyc;
  logic       port_hit;
  logic       strobe_held;
  logic       ack_now;

  logic [7:0] d_out_reg, d_out_next;
  logic       d_oe_reg, d_oe_next;
  logic       be_req_reg, be_req_next;
  logic       be_we_reg, be_we_next;
  logic [3:0] be_addr_reg, be_addr_next;
  logic [7:0] be_wdata_reg, be_wdata_next;
  logic       ack_seen_reg, ack_seen_next;
  logic       irq_ack_reg, irq_ack_next;
  logic       n_int_reg;

  logic       wg_load, wg_run, wg_done, wg_expiring;

  // The upper address byte carries the A register during I/O and is not decoded.
  wire unused_addr_hi = ^A[15:8];

  assign cyc         = decode_strobes(n_M1, n_IORQ, n_RD, n_WR, n_RFSH);
  assign port_hit    = ((A[7:0] ^ IO_BASE) & IO_MASK) == 8'h00;
  assign strobe_held = !n_IORQ && (be_we_reg ? !n_WR : !n_RD);
  assign ack_now     = ack_seen_reg || BE_ACK;

  z80_wait_gen #(
    .WAIT_STATES (WAIT_STATES)
  ) u_wait_gen (
    .clk          (CLK),
    .rst          (RESET),
    .load         (wg_load),
    .run          (wg_run),
    .wait_done    (wg_done),
    .cnt_expiring (wg_expiring),
    .n_wait       (n_WAIT)
  );

  // Next-state and next-output logic for the bus responder.
  always_comb begin
    state_next    = state_reg;
    d_out_next    = d_out_reg;
    d_oe_next     = d_oe_reg;
    be_req_next   = be_req_reg;
    be_we_next    = be_we_reg;
    be_addr_next  = be_addr_reg;
    be_wdata_next = be_wdata_reg;
    ack_seen_next = ack_seen_reg;
    irq_ack_next  = 1'b0;
    wg_load       = 1'b0;
    wg_run        = 1'b0;
    wg_done       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        ack_seen_next = 1'b0;
        if ((cyc == CYC_IO_RD || cyc == CYC_IO_WR) && port_hit) begin
          state_next    = ST_ACCESS;
          be_req_next   = 1'b1;
          be_we_next    = (cyc == CYC_IO_WR);
          be_addr_next  = A[3:0];
          be_wdata_next = D_IN;
          wg_load       = 1'b1;
          if (cyc == CYC_IO_RD) begin
            d_oe_next  = 1'b1;
            d_out_next = 8'h00;
          end
        end else if (cyc == CYC_INTA && !n_int_reg) begin
          state_next   = ST_INTA;
          d_out_next   = {VECTOR[7:1], 1'b0};
          d_oe_next    = 1'b1;
          irq_ack_next = 1'b1;
        end
      end
      ST_ACCESS: begin
        wg_run = 1'b1;
        if (!strobe_held) begin
          // CPU abandoned the cycle: drop everything, a late ack lands in IDLE.
          state_next    = ST_IDLE;
          be_req_next   = 1'b0;
          d_oe_next     = 1'b0;
          ack_seen_next = 1'b0;
          wg_done       = 1'b1;
        end else begin
          if (BE_ACK && !ack_seen_reg) begin
            ack_seen_next = 1'b1;
            be_req_next   = 1'b0;
            if (!be_we_reg) begin
              d_out_next = BE_RDATA;
            end
          end
          if (ack_now && wg_expiring) begin
            state_next  = ST_HOLD;
            be_req_next = 1'b0;
            wg_done     = 1'b1;
          end
        end
      end
      ST_HOLD, ST_INTA: begin
        if (n_IORQ) begin
          state_next = ST_IDLE;
          d_oe_next  = 1'b0;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State and output registers, all cleared immediately by RESET.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg    <= ST_IDLE;
      d_out_reg    <= 8'h00;
      d_oe_reg     <= 1'b0;
      be_req_reg   <= 1'b0;
      be_we_reg    <= 1'b0;
      be_addr_reg  <= 4'h0;
      be_wdata_reg <= 8'h00;
      ack_seen_reg <= 1'b0;
      irq_ack_reg  <= 1'b0;
      n_int_reg    <= 1'b1;
    end else begin
      state_reg    <= state_next;
      d_out_reg    <= d_out_next;
      d_oe_reg     <= d_oe_next;
      be_req_reg   <= be_req_next;
      be_we_reg    <= be_we_next;
      be_addr_reg  <= be_addr_next;
      be_wdata_reg <= be_wdata_next;
      ack_seen_reg <= ack_seen_next;
      irq_ack_reg  <= irq_ack_next;
      n_int_reg    <= ~IRQ;
    end
  end

  assign D_OUT    = d_out_reg;
  assign D_OE     = d_oe_reg;
  assign BE_REQ   = be_req_reg;
  assign BE_WE    = be_we_reg;
  assign BE_ADDR  = be_addr_reg;
  assign BE_WDATA = be_wdata_reg;
  assign IRQ_ACK  = irq_ack_reg;
  assign n_INT    = n_int_reg;

endmodule

// File: tb/tb_z80_io_responder.sv
// Scoreboard bench for z80_io_responder: stimulus pushes expected responses,
// a negedge monitor pops and compares them as the DUTs present results.
// A second instance with zero wait states shares the bus to cover that corner.
module tb_z80_io_responder;

  logic        clk = 1'b0;
  logic        RESET;
  logic [15:0] A;
  logic [7:0]  D_IN;
  logic        n_M1, n_IORQ, n_RD, n_WR, n_RFSH;
  logic [7:0]  BE_RDATA;
  logic        BE_ACK;
  logic        IRQ;

  logic [7:0] d_out, d_out0;
  logic       d_oe, d_oe0;
  logic       n_wait, n_wait0;
  logic       n_int, n_int0;
  logic       be_req, be_req0;
  logic       be_we, be_we0;
  logic [3:0] be_addr, be_addr0;
  logic [7:0] be_wdata, be_wdata0;
  logic       irq_ack, irq_ack0;

  always #5 clk = ~clk;

  z80_io_responder #(
    .WAIT_STATES (2),
    .VECTOR      (8'hE1)
  ) dut (
    .CLK(clk), .RESET(RESET), .A(A), .D_IN(D_IN), .D_OUT(d_out), .D_OE(d_oe),
    .n_M1(n_M1), .n_IORQ(n_IORQ), .n_RD(n_RD), .n_WR(n_WR), .n_RFSH(n_RFSH),
    .n_WAIT(n_wait), .n_INT(n_int), .BE_REQ(be_req), .BE_WE(be_we),
    .BE_ADDR(be_addr), .BE_WDATA(be_wdata), .BE_RDATA(BE_RDATA), .BE_ACK(BE_ACK),
    .IRQ(IRQ), .IRQ_ACK(irq_ack)
  );

  z80_io_responder #(
    .WAIT_STATES (0)
  ) dut0 (
    .CLK(clk), .RESET(RESET), .A(A), .D_IN(D_IN), .D_OUT(d_out0), .D_OE(d_oe0),
    .n_M1(n_M1), .n_IORQ(n_IORQ), .n_RD(n_RD), .n_WR(n_WR), .n_RFSH(n_RFSH),
    .n_WAIT(n_wait0), .n_INT(n_int0), .BE_REQ(be_req0), .BE_WE(be_we0),
    .BE_ADDR(be_addr0), .BE_WDATA(be_wdata0), .BE_RDATA(BE_RDATA), .BE_ACK(BE_ACK),
    .IRQ(IRQ), .IRQ_ACK(irq_ack0)
  );

  typedef enum logic [1:0] {K_ACC, K_INTA, K_SNAP} kind_e;

  typedef struct {
    kind_e      kind;
    logic [3:0] addr;
    logic       we;
    logic       chk_wdata;
    logic [7:0] wdata;
    logic       chk_dout;
    logic [7:0] dout;
    logic       doe;
    logic       n_wait;
    logic       n_int;
    logic       be_req;
    logic       irq_ack;
    logic       chk_be;
    int         wait_len;
    int         wait_len0;
  } exp_t;

  exp_t sb[$];

  // Owned by the stimulus process.
  int   snap_issued = 0;
  logic quiet = 1'b0;
  logic stim_done = 1'b0;

  // Owned by the monitor process.
  int total = 0;
  int bad = 0;
  int snap_done = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    A = 16'h0000; D_IN = 8'h00;
    n_M1 = 1'b1; n_IORQ = 1'b1; n_RD = 1'b1; n_WR = 1'b1; n_RFSH = 1'b1;
  endtask

  task automatic io_start(input logic [15:0] adr, input logic wr, input logic [7:0] wd);
    A = adr;
    D_IN = wr ? wd : 8'h00;
    n_IORQ = 1'b0;
    n_RD = wr;
    n_WR = ~wr;
  endtask

  task automatic push_acc(input logic [3:0] addr, input logic we, input logic cw,
                          input logic [7:0] wd, input logic cd, input logic [7:0] dout,
                          input logic doe, input int wl, input int wl0);
    exp_t e;
    e = '{kind: K_ACC, addr: addr, we: we, chk_wdata: cw, wdata: wd, chk_dout: cd,
          dout: dout, doe: doe, n_wait: 1'b1, n_int: 1'b1, be_req: 1'b0,
          irq_ack: 1'b0, chk_be: 1'b1, wait_len: wl, wait_len0: wl0};
    sb.push_back(e);
  endtask

  task automatic push_snap(input logic nw, input logic doe, input logic [7:0] dout,
                           input logic req, input logic ni, input logic ia,
                           input logic cb, input logic [3:0] addr, input logic we,
                           input logic [7:0] wd);
    exp_t e;
    e = '{kind: K_SNAP, addr: addr, we: we, chk_wdata: cb, wdata: wd, chk_dout: 1'b1,
          dout: dout, doe: doe, n_wait: nw, n_int: ni, be_req: req, irq_ack: ia,
          chk_be: cb, wait_len: 0, wait_len0: 0};
    sb.push_back(e);
    snap_issued++;
  endtask

  initial begin
    RESET = 1'b1; BE_ACK = 1'b0; BE_RDATA = 8'h00; IRQ = 1'b0;
    bus_idle();
    cyc(2);
    push_snap(1, 0, 8'h00, 0, 1, 0, 1, 4'h0, 0, 8'h00);
    cyc(1);
    RESET = 1'b0;
    cyc(2);

    // Write 5A to port 43, ack in the first ACCESS cycle.
    push_acc(4'h3, 1, 1, 8'h5A, 0, 8'h00, 0, 2, 1);
    io_start(16'h1243, 1'b1, 8'h5A);
    cyc(1); BE_ACK = 1'b1;
    cyc(1); BE_ACK = 1'b0;
    cyc(3); bus_idle();
    cyc(2);

    // Read port 41, ack arrives in the sixth ACCESS cycle.
    push_acc(4'h1, 0, 0, 8'h00, 1, 8'hC3, 1, 6, 6);
    io_start(16'hAB41, 1'b0, 8'h00);
    BE_RDATA = 8'hC3;
    cyc(6); BE_ACK = 1'b1;
    cyc(1); BE_ACK = 1'b0;
    cyc(2);
    push_snap(1, 1, 8'hC3, 0, 1, 0, 0, 4'h0, 0, 8'h00);
    bus_idle();
    cyc(1);
    push_snap(1, 0, 8'hC3, 0, 1, 0, 0, 4'h0, 0, 8'h00);
    cyc(1);

    // Read port 42 aborted by the CPU, then a late ack that must be ignored.
    push_acc(4'h2, 0, 0, 8'h00, 1, 8'h00, 0, 3, 3);
    io_start(16'h0042, 1'b0, 8'h00);
    BE_RDATA = 8'h99;
    cyc(3); bus_idle();
    cyc(1); BE_ACK = 1'b1;
    cyc(1); BE_ACK = 1'b0;
    cyc(1);
    push_snap(1, 0, 8'h00, 0, 1, 0, 0, 4'h0, 0, 8'h00);
    cyc(1);

    // Cycles that must get no response at all.
    quiet = 1'b1;
    io_start(16'h0050, 1'b0, 8'h00);
    cyc(4); bus_idle(); cyc(1);
    A = 16'h0041; n_RFSH = 1'b0; n_IORQ = 1'b0; n_RD = 1'b0;
    cyc(3); bus_idle(); cyc(1);
    A = 16'h0041; n_IORQ = 1'b0; n_RD = 1'b0; n_WR = 1'b0;
    cyc(3); bus_idle(); cyc(1);
    n_M1 = 1'b0; n_IORQ = 1'b0;
    cyc(3); bus_idle(); cyc(2);
    quiet = 1'b0;

    // Interrupt request and acknowledge.
    IRQ = 1'b1;
    cyc(2);
    push_snap(1, 0, 8'h00, 0, 0, 0, 0, 4'h0, 0, 8'h00);
    sb.push_back('{kind: K_INTA, addr: 4'h0, we: 1'b0, chk_wdata: 1'b0, wdata: 8'h00,
                   chk_dout: 1'b1, dout: 8'hE0, doe: 1'b1, n_wait: 1'b1, n_int: 1'b0,
                   be_req: 1'b0, irq_ack: 1'b1, chk_be: 1'b0, wait_len: 0, wait_len0: 0});
    n_M1 = 1'b0; n_IORQ = 1'b0;
    cyc(2);
    push_snap(1, 1, 8'hE0, 0, 0, 0, 0, 4'h0, 0, 8'h00);
    bus_idle();
    cyc(2);
    push_snap(1, 0, 8'hE0, 0, 0, 0, 0, 4'h0, 0, 8'h00);
    IRQ = 1'b0;
    cyc(2);
    push_snap(1, 0, 8'hE0, 0, 1, 0, 0, 4'h0, 0, 8'h00);
    cyc(1);

    // Reset in the second ACCESS cycle of a read.
    push_acc(4'h0, 0, 1, 8'h00, 1, 8'h00, 0, 1, 1);
    io_start(16'h0041, 1'b0, 8'h00);
    BE_RDATA = 8'h77;
    cyc(2);
    #1;
    RESET = 1'b1;
    bus_idle();
    push_snap(1, 0, 8'h00, 0, 1, 0, 1, 4'h0, 0, 8'h00);
    cyc(1);
    RESET = 1'b0;
    cyc(2);

    // Normal write after reset, ack in the second ACCESS cycle.
    push_acc(4'hF, 1, 1, 8'h3C, 0, 8'h00, 0, 2, 2);
    io_start(16'h004F, 1'b1, 8'h3C);
    cyc(2); BE_ACK = 1'b1;
    cyc(1); BE_ACK = 1'b0;
    cyc(2);
    bus_idle();
    cyc(2);
    push_snap(1, 0, 8'h00, 0, 1, 0, 1, 4'hF, 1, 8'h3C);
    cyc(5);
    stim_done = 1'b1;
  end

  // ---------------- monitor ----------------
  initial begin
    int   run = 0;
    int   run0 = 0;
    int   last0 = 0;
    int   cycles = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      cycles++;

      if (!n_wait0) begin
        run0++;
      end else if (run0 != 0) begin
        last0 = run0;
        run0 = 0;
      end

      if (!n_wait) begin
        run++;
      end else if (run != 0) begin
        if (sb.size() == 0 || sb[0].kind != K_ACC) begin
          chk("acc_expected", 16'(1), 16'(0));
        end else begin
          e = sb.pop_front();
          $display("acc addr=%0h we=%0b wdata=%02h dout=%02h wait=%0d wait0=%0d",
                   be_addr, be_we, be_wdata, d_out, run, last0);
          chk("acc_addr", 16'(be_addr), 16'(e.addr));
          chk("acc_we", 16'(be_we), 16'(e.we));
          chk("acc_req", 16'(be_req), 16'(e.be_req));
          chk("acc_doe", 16'(d_oe), 16'(e.doe));
          chk("acc_wait", 16'(run), 16'(e.wait_len));
          chk("acc0_wait", 16'(last0), 16'(e.wait_len0));
          chk("acc0_addr", 16'(be_addr0), 16'(e.addr));
          chk("acc0_we", 16'(be_we0), 16'(e.we));
          chk("acc0_doe", 16'(d_oe0), 16'(e.doe));
          if (e.chk_wdata) begin
            chk("acc_wdata", 16'(be_wdata), 16'(e.wdata));
            chk("acc0_wdata", 16'(be_wdata0), 16'(e.wdata));
          end
          if (e.chk_dout) begin
            chk("acc_dout", 16'(d_out), 16'(e.dout));
            chk("acc0_dout", 16'(d_out0), 16'(e.dout));
          end
        end
        run = 0;
        last0 = 0;
      end

      if (irq_ack) begin
        if (sb.size() == 0 || sb[0].kind != K_INTA) begin
          chk("inta_expected", 16'(1), 16'(0));
        end else begin
          e = sb.pop_front();
          $display("inta vector=%02h oe=%0b n_wait=%0b n_int=%0b", d_out, d_oe, n_wait, n_int);
          chk("inta_dout", 16'(d_out), 16'(e.dout));
          chk("inta_doe", 16'(d_oe), 16'(e.doe));
          chk("inta_wait", 16'(n_wait), 16'(e.n_wait));
          chk("inta_nint", 16'(n_int), 16'(e.n_int));
          chk("inta0_ack", 16'(irq_ack0), 16'(e.irq_ack));
        end
      end

      if (snap_issued != snap_done) begin
        snap_done++;
        if (sb.size() == 0) begin
          chk("snap_expected", 16'(1), 16'(0));
        end else begin
          e = sb.pop_front();
          $display("snap n_wait=%0b oe=%0b dout=%02h req=%0b n_int=%0b iack=%0b addr=%0h",
                   n_wait, d_oe, d_out, be_req, n_int, irq_ack, be_addr);
          chk("snap_kind", 16'(e.kind), 16'(K_SNAP));
          chk("snap_wait", 16'(n_wait), 16'(e.n_wait));
          chk("snap_doe", 16'(d_oe), 16'(e.doe));
          chk("snap_dout", 16'(d_out), 16'(e.dout));
          chk("snap_req", 16'(be_req), 16'(e.be_req));
          chk("snap_nint", 16'(n_int), 16'(e.n_int));
          chk("snap0_nint", 16'(n_int0), 16'(e.n_int));
          chk("snap_iack", 16'(irq_ack), 16'(e.irq_ack));
          if (e.chk_be) begin
            chk("snap_addr", 16'(be_addr), 16'(e.addr));
            chk("snap_we", 16'(be_we), 16'(e.we));
            chk("snap_wdata", 16'(be_wdata), 16'(e.wdata));
          end
        end
      end

      if (quiet) begin
        chk("quiet_req", 16'(be_req), 16'(0));
        chk("quiet_wait", 16'(n_wait), 16'(1));
        chk("quiet_doe", 16'(d_oe), 16'(0));
        chk("quiet_iack", 16'(irq_ack), 16'(0));
        chk("quiet0_req", 16'(be_req0), 16'(0));
        chk("quiet0_wait", 16'(n_wait0), 16'(1));
        chk("quiet0_doe", 16'(d_oe0), 16'(0));
        chk("quiet0_iack", 16'(irq_ack0), 16'(0));
      end

      if (stim_done) begin
        chk("sb_empty", 16'(sb.size()), 16'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end

      if (cycles > 3000) begin
        chk("timeout", 16'(1), 16'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  end

endmodule
